lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared op, error and state encodings for the load/store unit
package lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_LD_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ST_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_RANGE       = 2'b11;

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Range is checked first so a far-away misaligned address reports out-of-range.
  function automatic logic [1:0] check_op(op_e op, logic [31:0] addr, logic [31:0] addr_max);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = addr[0];
      default:              mis = 1'b0;
    endcase
    if (addr > addr_max) begin
      return ERR_RANGE;
    end else if (mis) begin
      return is_store(op) ? ERR_ST_MISALIGN : ERR_LD_MISALIGN;
    end else begin
      return ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - picks the addressed lane of a read word and extends it
module lsu_load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  op_e         op,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {24'h000000, byte_lane};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'h0000, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store unit: one op accepted, one memory request, one result
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_MAX = 32'h0000_2FFF,
  parameter int          OP_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OP_W-1:0] op_type,
  input  logic [31:0]     op_addr,
  input  logic [31:0]     op_wdata,
  input  logic [31:0]     op_pc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ack,
  output logic            ld_valid,
  output logic [31:0]     ld_data,
  output logic            st_done,
  output logic            err_valid,
  output logic [1:0]      err_code,
  output logic [31:0]     err_pc
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] addr_q, wdata_q, pc_q, ld_data_q;
  logic [1:0]  err_code_q;

  op_e         op_in;
  logic [1:0]  chk;
  logic        st_q;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] align_data;

  assign op_in = op_e'(op_type[2:0]);
  assign chk   = check_op(op_in, op_addr, ADDR_MAX);
  assign st_q  = is_store(op_q);

  lsu_load_align u_align (
    .rdata (mem_rdata),
    .off   (addr_q[1:0]),
    .op    (op_q),
    .data  (align_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LW;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      pc_q       <= 32'h0;
      err_code_q <= ERR_NONE;
      ld_data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && op_valid) begin
        op_q       <= op_in;
        addr_q     <= op_addr;
        wdata_q    <= op_wdata;
        pc_q       <= op_pc;
        err_code_q <= chk;
      end
      if (state_q == ST_REQ && mem_ack && !st_q) begin
        ld_data_q <= align_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ld_valid  = 1'b0;
    st_done   = 1'b0;
    err_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = (chk != ERR_NONE) ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        mem_we  = st_q;
        if (mem_ack) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ld_valid = !st_q;
        st_done  = st_q;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        err_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Narrow stores replicate their data on every lane so the byte enables alone pick the target.
  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = wdata_q;
    case (op_q)
      OP_SH: begin
        be_lane    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      OP_SB: begin
        be_lane    = 4'b0001 << addr_q[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      default: begin
        be_lane    = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = mem_req ? be_lane : 4'b0000;
  assign mem_wdata = wdata_lane;
  assign ld_data   = ld_data_q;
  assign err_code  = err_code_q;
  assign err_pc    = pc_q;

endmodule
